// File: rtl/alu_pkg.sv
// Shared opcode enums, FSM states, operand timeout and the operand-requirement
// helpers used by the ALU core and its execution unit.
package alu_pkg;

    localparam int WAIT_CYCLES = 16;

    typedef enum logic [3:0] {
        ARITH_ADD     = 4'd0,
        ARITH_SUB     = 4'd1,
        ARITH_ADD_CIN = 4'd2,
        ARITH_SUB_CIN = 4'd3,
        ARITH_INC_A   = 4'd4,
        ARITH_DEC_A   = 4'd5,
        ARITH_INC_B   = 4'd6,
        ARITH_DEC_B   = 4'd7,
        ARITH_CMP     = 4'd8
    } arith_cmd_e;

    typedef enum logic [3:0] {
        LOGIC_AND    = 4'd0,
        LOGIC_NAND   = 4'd1,
        LOGIC_OR     = 4'd2,
        LOGIC_NOR    = 4'd3,
        LOGIC_XOR    = 4'd4,
        LOGIC_XNOR   = 4'd5,
        LOGIC_NOT_A  = 4'd6,
        LOGIC_NOT_B  = 4'd7,
        LOGIC_SHR1_A = 4'd8,
        LOGIC_SHL1_A = 4'd9,
        LOGIC_SHR1_B = 4'd10,
        LOGIC_SHL1_B = 4'd11,
        LOGIC_ROL    = 4'd12,
        LOGIC_ROR    = 4'd13
    } logic_cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Invalid opcodes need no operand, so they complete on their first beat.
    function automatic logic needs_a(input logic mode, input logic [3:0] cmd);
        logic r;
        r = 1'b0;
        if (mode) begin
            case (cmd)
                ARITH_ADD, ARITH_SUB, ARITH_ADD_CIN, ARITH_SUB_CIN,
                ARITH_INC_A, ARITH_DEC_A, ARITH_CMP: r = 1'b1;
                default: r = 1'b0;
            endcase
        end else begin
            case (cmd)
                LOGIC_AND, LOGIC_NAND, LOGIC_OR, LOGIC_NOR, LOGIC_XOR, LOGIC_XNOR,
                LOGIC_NOT_A, LOGIC_SHR1_A, LOGIC_SHL1_A, LOGIC_ROL, LOGIC_ROR: r = 1'b1;
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic needs_b(input logic mode, input logic [3:0] cmd);
        logic r;
        r = 1'b0;
        if (mode) begin
            case (cmd)
                ARITH_ADD, ARITH_SUB, ARITH_ADD_CIN, ARITH_SUB_CIN,
                ARITH_INC_B, ARITH_DEC_B, ARITH_CMP: r = 1'b1;
                default: r = 1'b0;
            endcase
        end else begin
            case (cmd)
                LOGIC_AND, LOGIC_NAND, LOGIC_OR, LOGIC_NOR, LOGIC_XOR, LOGIC_XNOR,
                LOGIC_NOT_B, LOGIC_SHR1_B, LOGIC_SHL1_B, LOGIC_ROL, LOGIC_ROR: r = 1'b1;
                default: r = 1'b0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_if.sv
// ALU driver/monitor bus: operand/command inputs and registered result/flags.
interface alu_if #(parameter int DATA_WIDTH = 8);
    logic                  CE;
    logic                  MODE;
    logic [3:0]            CMD;
    logic [1:0]            INP_VALID;
    logic [DATA_WIDTH-1:0] OPA;
    logic [DATA_WIDTH-1:0] OPB;
    logic                  CIN;
    logic [DATA_WIDTH+1:0] RES;
    logic                  ERR;
    logic                  OFLOW;
    logic                  COUT;
    logic                  G;
    logic                  L;
    logic                  E;

    modport master (
        output CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        input  RES, ERR, OFLOW, COUT, G, L, E
    );

    modport slave (
        input  CE, MODE, CMD, INP_VALID, OPA, OPB, CIN,
        output RES, ERR, OFLOW, COUT, G, L, E
    );
endinterface

// File: rtl/alu_exec.sv
// Combinational ALU: computes the result and every status flag for one
// operation; flags not produced by the operation are driven low.
module alu_exec
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  mode_i,
    input  logic [3:0]            cmd_i,
    input  logic                  cin_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH+1:0] res_o,
    output logic                  err_o,
    output logic                  oflow_o,
    output logic                  cout_o,
    output logic                  g_o,
    output logic                  l_o,
    output logic                  e_o
);
    localparam int W  = DATA_WIDTH;
    localparam int LW = $clog2(W);

    logic [W:0]     a_x, b_x, c_x, wide;
    logic [W-1:0]   narrow;
    logic [2*W-1:0] rol_w, ror_w;
    logic [LW-1:0]  amt;
    logic           rot_bad;

    always_comb begin
        a_x     = {1'b0, a_i};
        b_x     = {1'b0, b_i};
        c_x     = {{W{1'b0}}, cin_i};
        amt     = b_i[LW-1:0];
        rot_bad = |b_i[W-1:LW];
        // Rotating a doubled copy keeps the wrapped-around bits in one window.
        rol_w   = {a_i, a_i} << amt;
        ror_w   = {a_i, a_i} >> amt;
        wide    = '0;
        narrow  = '0;
        res_o   = '0;
        err_o   = 1'b0;
        oflow_o = 1'b0;
        cout_o  = 1'b0;
        g_o     = 1'b0;
        l_o     = 1'b0;
        e_o     = 1'b0;
        if (mode_i) begin
            case (cmd_i)
                ARITH_ADD:     begin wide = a_x + b_x;       cout_o  = wide[W];     end
                ARITH_SUB:     begin wide = a_x - b_x;       oflow_o = (a_x < b_x); end
                ARITH_ADD_CIN: begin wide = a_x + b_x + c_x; cout_o  = wide[W];     end
                ARITH_SUB_CIN: begin
                    wide    = a_x - b_x - c_x;
                    oflow_o = (a_x < (b_x + c_x));
                end
                ARITH_INC_A:   wide = a_x + (W+1)'(1);
                ARITH_DEC_A:   wide = a_x - (W+1)'(1);
                ARITH_INC_B:   wide = b_x + (W+1)'(1);
                ARITH_DEC_B:   wide = b_x - (W+1)'(1);
                ARITH_CMP: begin
                    g_o = (a_i > b_i);
                    l_o = (a_i < b_i);
                    e_o = (a_i == b_i);
                end
                default:       err_o = 1'b1;
            endcase
            res_o = {1'b0, wide};
        end else begin
            case (cmd_i)
                LOGIC_AND:    narrow = a_i & b_i;
                LOGIC_NAND:   narrow = ~(a_i & b_i);
                LOGIC_OR:     narrow = a_i | b_i;
                LOGIC_NOR:    narrow = ~(a_i | b_i);
                LOGIC_XOR:    narrow = a_i ^ b_i;
                LOGIC_XNOR:   narrow = ~(a_i ^ b_i);
                LOGIC_NOT_A:  narrow = ~a_i;
                LOGIC_NOT_B:  narrow = ~b_i;
                LOGIC_SHR1_A: narrow = a_i >> 1;
                LOGIC_SHL1_A: narrow = a_i << 1;
                LOGIC_SHR1_B: narrow = b_i >> 1;
                LOGIC_SHL1_B: narrow = b_i << 1;
                LOGIC_ROL:    begin narrow = rol_w[2*W-1:W]; err_o = rot_bad; end
                LOGIC_ROR:    begin narrow = ror_w[W-1:0];   err_o = rot_bad; end
                default:      err_o = 1'b1;
            endcase
            res_o = {2'b00, narrow};
        end
    end
endmodule

// File: rtl/alu_core.sv
// Registered ALU: pairs operands arriving in separate beats (bounded wait),
// runs them through alu_exec and holds result/flags until the next operation.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input logic  clk,
    input logic  rst,
    alu_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(WAIT_CYCLES + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d, cin_q, cin_d;
    logic [3:0]      cmd_q, cmd_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            a_ok_q, a_ok_d, b_ok_q, b_ok_d;
    logic [W+1:0]    res_q, res_d;
    logic            err_q, err_d, oflow_q, oflow_d, cout_q, cout_d;
    logic            g_q, g_d, l_q, l_d, e_q, e_d;
    logic            active, done, tmo;
    logic [W+1:0]    x_res;
    logic            x_err, x_oflow, x_cout, x_g, x_l, x_e;

    // Execution sees the post-latch view, so a completing beat computes on
    // the same edge that captures it.
    alu_exec #(.DATA_WIDTH(W)) u_exec (
        .mode_i  (mode_d),
        .cmd_i   (cmd_d),
        .cin_i   (cin_d),
        .a_i     (a_d),
        .b_i     (b_d),
        .res_o   (x_res),
        .err_o   (x_err),
        .oflow_o (x_oflow),
        .cout_o  (x_cout),
        .g_o     (x_g),
        .l_o     (x_l),
        .e_o     (x_e)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        cmd_d   = cmd_q;
        cin_d   = cin_q;
        a_d     = a_q;
        b_d     = b_q;
        a_ok_d  = a_ok_q;
        b_ok_d  = b_ok_q;
        active  = 1'b0;
        done    = 1'b0;
        tmo     = 1'b0;
        if (bus.CE) begin
            if (state_q == IDLE) begin
                if (bus.INP_VALID != 2'b00) begin
                    active  = 1'b1;
                    mode_d  = bus.MODE;
                    cmd_d   = bus.CMD;
                    cin_d   = bus.CIN;
                    a_ok_d  = bus.INP_VALID[0];
                    b_ok_d  = bus.INP_VALID[1];
                    if (bus.INP_VALID[0]) a_d = bus.OPA;
                    if (bus.INP_VALID[1]) b_d = bus.OPB;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end else begin
                active = 1'b1;
                if (!a_ok_q && bus.INP_VALID[0]) begin a_d = bus.OPA; a_ok_d = 1'b1; end
                if (!b_ok_q && bus.INP_VALID[1]) begin b_d = bus.OPB; b_ok_d = 1'b1; end
                cnt_d = cnt_q + CW'(1);
            end
            done = active && (!needs_a(mode_d, cmd_d) || a_ok_d)
                          && (!needs_b(mode_d, cmd_d) || b_ok_d);
            tmo  = !done && (state_q == WAIT) && (cnt_d == CW'(WAIT_CYCLES));
            if (done || tmo) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        res_d   = res_q;
        err_d   = err_q;
        oflow_d = oflow_q;
        cout_d  = cout_q;
        g_d     = g_q;
        l_d     = l_q;
        e_d     = e_q;
        if (done) begin
            res_d   = x_res;
            err_d   = x_err;
            oflow_d = x_oflow;
            cout_d  = x_cout;
            g_d     = x_g;
            l_d     = x_l;
            e_d     = x_e;
        end else if (tmo) begin
            res_d   = '0;
            err_d   = 1'b1;
            oflow_d = 1'b0;
            cout_d  = 1'b0;
            g_d     = 1'b0;
            l_d     = 1'b0;
            e_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            cmd_q   <= '0;
            cin_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            a_ok_q  <= 1'b0;
            b_ok_q  <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
            oflow_q <= 1'b0;
            cout_q  <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            cin_q   <= cin_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_ok_q  <= a_ok_d;
            b_ok_q  <= b_ok_d;
            res_q   <= res_d;
            err_q   <= err_d;
            oflow_q <= oflow_d;
            cout_q  <= cout_d;
            g_q     <= g_d;
            l_q     <= l_d;
            e_q     <= e_d;
        end
    end

    assign bus.RES   = res_q;
    assign bus.ERR   = err_q;
    assign bus.OFLOW = oflow_q;
    assign bus.COUT  = cout_q;
    assign bus.G     = g_q;
    assign bus.L     = l_q;
    assign bus.E     = e_q;
endmodule

// File: tb/tb_alu_core.sv
// Bench for alu_core: directed cases plus randomized split/joined operand
// traffic, scored against a plain-arithmetic reference model.
module tb_alu_core;
    localparam int W  = 8;
    localparam int OW = W + 8;

    logic clk = 1'b0;
    logic rst;
    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;

    logic [15:0] na_ar = 16'h013F;
    logic [15:0] nb_ar = 16'h01CF;
    logic [15:0] na_lo = 16'h337F;
    logic [15:0] nb_lo = 16'h3CBF;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_if #(.DATA_WIDTH(W)) bus ();
    alu_core #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int              due;
        logic [OW-1:0]   exp;
        string           name;
    } exp_t;
    exp_t sb[$];

    function automatic logic [OW-1:0] pack(input int res, input bit er, input bit ov,
                                           input bit co, input bit gt, input bit lt, input bit eq);
        logic [W+1:0] r;
        r = (W+2)'(res);
        return {r, er, ov, co, gt, lt, eq};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {bus.RES, bus.ERR, bus.OFLOW, bus.COUT, bus.G, bus.L, bus.E};
    endfunction

    // Reference behaviour written directly from the opcode table.
    function automatic logic [OW-1:0] model(input bit mode, input int cmd, input bit cin,
                                            input int a, input int b);
        int r, m, amt;
        bit er, ov, co, gt, lt, eq;
        r = 0; m = 1 << W; amt = 0;
        er = 0; ov = 0; co = 0; gt = 0; lt = 0; eq = 0;
        if (mode) begin
            case (cmd)
                0: begin r = a + b; co = (r >= m); end
                1: begin r = a - b; ov = (a < b); end
                2: begin r = a + b + int'(cin); co = (r >= m); end
                3: begin r = a - b - int'(cin); ov = (a < b + int'(cin)); end
                4: r = a + 1;
                5: r = a - 1;
                6: r = b + 1;
                7: r = b - 1;
                8: begin gt = (a > b); lt = (a < b); eq = (a == b); end
                default: er = 1;
            endcase
            if (r < 0) r = r + 2 * m;
            r = r % (2 * m);
        end else begin
            case (cmd)
                0: r = a & b;
                1: r = (a & b) ^ (m - 1);
                2: r = a | b;
                3: r = (a | b) ^ (m - 1);
                4: r = a ^ b;
                5: r = (a ^ b) ^ (m - 1);
                6: r = a ^ (m - 1);
                7: r = b ^ (m - 1);
                8: r = a / 2;
                9: r = (a * 2) % m;
                10: r = b / 2;
                11: r = (b * 2) % m;
                12, 13: begin
                    amt = b % W;
                    er  = (b >= W);
                    r   = a;
                    for (int i = 0; i < amt; i++)
                        r = (cmd == 12) ? ((r * 2) % m + r / (m / 2))
                                        : (r / 2 + (r % 2) * (m / 2));
                end
                default: er = 1;
            endcase
        end
        return pack(r, er, ov, co, gt, lt, eq);
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got RES=%h err/of/co/g/l/e=%b, required RES=%h err/of/co/g/l/e=%b",
                      name, act[OW-1:6], act[5:0], exp[OW-1:6], exp[5:0]);
    endtask

    task automatic drive(input bit ce, input logic [1:0] vld, input bit mode,
                         input logic [3:0] cmd, input bit cin,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.CE        = ce;
        bus.INP_VALID = vld;
        bus.MODE      = mode;
        bus.CMD       = cmd;
        bus.CIN       = cin;
        bus.OPA       = a;
        bus.OPB       = b;
    endtask

    task automatic drive_junk(input bit ce, input logic [1:0] vld);
        drive(ce, vld, 1'($urandom), 4'($urandom), 1'($urandom), W'($urandom), W'($urandom));
    endtask

    task automatic expect_next(input logic [OW-1:0] e, input string name);
        exp_t t;
        t.due  = cyc + 1;
        t.exp  = e;
        t.name = name;
        sb.push_back(t);
    endtask

    // Monitor: every cycle the outputs must equal the most recent completed
    // result; a scheduled result replaces it on its due cycle.
    initial begin
        logic [OW-1:0] last;
        exp_t          t;
        string         nm;
        last = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                last = '0;
                continue;
            end
            nm = "hold";
            if (sb.size() > 0 && sb[0].due == cyc) begin
                t    = sb.pop_front();
                last = t.exp;
                nm   = t.name;
            end
            check(nm, obs(), last);
        end
    end

    initial begin
        bit           mode, cin;
        logic [3:0]   cmd;
        logic [W-1:0] a, b;
        logic [1:0]   need, v1, miss, v2;
        int           gap, g;

        rst = 1'b0;
        bus.CE = 1'b0; bus.INP_VALID = 2'b00; bus.MODE = 1'b0; bus.CMD = 4'd0;
        bus.CIN = 1'b0; bus.OPA = '0; bus.OPB = '0;
        #1 check("reset_state", obs(), '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        drive(1'b1, 2'b11, 1'b1, 4'd0, 1'b0, 8'hFF, 8'h01);
        expect_next(pack(32'h100, 0, 0, 1, 0, 0, 0), "add_ff_01");

        drive(1'b1, 2'b01, 1'b1, 4'd0, 1'b0, 8'd5, 8'hAA);
        repeat (4) drive(1'b1, 2'b00, 1'b0, 4'd7, 1'b1, 8'hEE, 8'hEE);
        drive(1'b1, 2'b10, 1'b1, 4'd1, 1'b0, 8'h55, 8'd3);
        expect_next(pack(8, 0, 0, 0, 0, 0, 0), "split_add");

        drive(1'b1, 2'b01, 1'b1, 4'd0, 1'b0, 8'd7, 8'd0);
        repeat (16) drive(1'b1, 2'b00, 1'b1, 4'd0, 1'b0, 8'd0, 8'd0);
        expect_next(pack(0, 1, 0, 0, 0, 0, 0), "timeout");

        drive(1'b1, 2'b11, 1'b1, 4'd0, 1'b0, 8'd1, 8'd1);
        expect_next(pack(2, 0, 0, 0, 0, 0, 0), "add_1_1");
        drive(1'b1, 2'b01, 1'b1, 4'd0, 1'b0, 8'd7, 8'd0);
        for (int i = 0; i < 19; i++) begin
            if (i == 2 || i == 7 || i == 12) drive(1'b0, 2'b10, 1'b1, 4'd0, 1'b0, 8'd0, 8'd9);
            else                             drive(1'b1, 2'b00, 1'b1, 4'd0, 1'b0, 8'd0, 8'd0);
        end
        expect_next(pack(0, 1, 0, 0, 0, 0, 0), "timeout_ce_gaps");

        drive(1'b1, 2'b11, 1'b0, 4'd12, 1'b0, 8'h81, 8'h01);
        expect_next(pack(3, 0, 0, 0, 0, 0, 0), "rol_ok");
        drive(1'b1, 2'b11, 1'b0, 4'd12, 1'b0, 8'h81, 8'h11);
        expect_next(pack(3, 1, 0, 0, 0, 0, 0), "rol_bad_amt");
        drive(1'b1, 2'b11, 1'b1, 4'd8, 1'b0, 8'd10, 8'd20);
        expect_next(pack(0, 0, 0, 0, 0, 1, 0), "cmp_lt");
        drive(1'b1, 2'b11, 1'b1, 4'd8, 1'b0, 8'd20, 8'd20);
        expect_next(pack(0, 0, 0, 0, 0, 0, 1), "cmp_eq");
        drive(1'b1, 2'b11, 1'b1, 4'd12, 1'b0, 8'd3, 8'd4);
        expect_next(pack(0, 1, 0, 0, 0, 0, 0), "invalid_cmd");

        drive(1'b1, 2'b01, 1'b1, 4'd0, 1'b0, 8'd9, 8'd0);
        repeat (9) drive(1'b1, 2'b00, 1'b1, 4'd0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("reset_mid_wait", obs(), '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 2'b11, 1'b1, 4'd0, 1'b0, 8'd2, 8'd3);
        expect_next(pack(5, 0, 0, 0, 0, 0, 0), "add_after_reset");

        for (int t = 0; t < 150; t++) begin
            mode = 1'($urandom);
            cmd  = 4'($urandom);
            cin  = 1'($urandom);
            a    = W'($urandom);
            b    = W'($urandom);
            need = mode ? {nb_ar[cmd], na_ar[cmd]} : {nb_lo[cmd], na_lo[cmd]};
            v1   = 2'($urandom_range(1, 3));
            drive(1'b1, v1, mode, cmd, cin, v1[0] ? a : W'($urandom), v1[1] ? b : W'($urandom));
            miss = need & ~v1;
            if (miss != 2'b00) begin
                gap = $urandom_range(0, 4);
                g   = 0;
                while (g < gap) begin
                    if ($urandom_range(0, 3) == 0) drive_junk(1'b0, 2'($urandom));
                    else begin
                        drive_junk(1'b1, $urandom_range(0, 1) ? v1 : 2'b00);
                        g++;
                    end
                end
                v2 = miss | ($urandom_range(0, 1) ? v1 : 2'b00);
                drive(1'b1, v2, 1'($urandom), 4'($urandom), 1'($urandom),
                      miss[0] ? a : W'($urandom), miss[1] ? b : W'($urandom));
            end
            expect_next(model(mode, int'(cmd), cin, int'(a), int'(b)), $sformatf("rand%0d", t));
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 2) == 0) drive_junk(1'b0, 2'($urandom));
                else                           drive_junk(1'b1, 2'b00);
            end
        end

        repeat (3) drive_junk(1'b1, 2'b00);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL pending_results: %0d still queued, required 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
